// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage data RAM and its EDIT_SERIAL decoder.
package mem_pkg;

  localparam int unsigned DEPTH  = 512;
  localparam int unsigned ADDR_W = 9;

  // EDIT_SERIAL field positions
  localparam int unsigned WR_BIT  = 64;
  localparam int unsigned ADDR_HI = 63;
  localparam int unsigned ADDR_LO = 32;
  localparam int unsigned DATA_HI = 31;

  typedef enum logic [1:0] {
    StRun,
    StDump,
    StDone
  } dump_state_e;

endpackage

// File: rtl/mem_edit_decode.sv
// Combinational split of an EDIT_SERIAL request into write flag, word index,
// write data and an address-legality flag.
module mem_edit_decode
  import mem_pkg::*;
#(
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic [64:0]      edit_serial_i,
  output logic             we_o,
  output logic [AddrW-1:0] idx_o,
  output logic [31:0]      wdata_o,
  output logic             addr_ok_o
);

  logic [31:0] addr;

  assign addr    = edit_serial_i[ADDR_HI:ADDR_LO];
  assign we_o    = edit_serial_i[WR_BIT];
  assign wdata_o = edit_serial_i[DATA_HI:0];
  assign idx_o   = addr[AddrW+1:2];
  // Word-aligned and inside the RAM; upper bits must be clear.
  assign addr_ok_o = (addr[1:0] == 2'b00) && (addr[31:AddrW+2] == '0);

endmodule

// File: rtl/mem_edit_responder.sv
// Memory-stage data RAM, EDIT_SERIAL responder and end-of-program dump port.
// Optional access counters are enabled by defining MEM_ACCESS_COUNT_EN.
module mem_edit_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = mem_pkg::DEPTH,
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [64:0]       EDIT_SERIAL,
  input  logic              ENABLE_MEM,
  input  logic              HALT,
  output logic [31:0]       READ_DATA,
  output logic              READ_VALID,
  output logic              ADDR_ERR,
  output logic              BUSY,
  output logic              DUMP_VALID,
  input  logic              DUMP_READY,
  output logic [ADDR_W-1:0] DUMP_ADDR,
  output logic [31:0]       DUMP_DATA,
  output logic              DUMP_DONE,
  output logic [31:0]       WR_COUNT,
  output logic [31:0]       RD_COUNT
);

  logic              req_we;
  logic [ADDR_W-1:0] req_idx;
  logic [31:0]       req_wdata;
  logic              req_ok;

  mem_edit_decode #(
    .AddrW(ADDR_W)
  ) u_decode (
    .edit_serial_i(EDIT_SERIAL),
    .we_o         (req_we),
    .idx_o        (req_idx),
    .wdata_o      (req_wdata),
    .addr_ok_o    (req_ok)
  );

  dump_state_e       state_q;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       read_data_q;
  logic              read_valid_q;
  logic              addr_err_q;
  logic              busy_q;
  logic              dump_valid_q;
  logic [ADDR_W-1:0] dump_addr_q;
  logic              dump_done_q;

  // Requests are only honoured while running; dump and done freeze the RAM.
  logic req_active;
  logic wr_hit;
  logic rd_hit;

  assign req_active = (state_q == StRun) && ENABLE_MEM;
  assign wr_hit     = req_active && req_ok && req_we;
  assign rd_hit     = req_active && req_ok && !req_we;

  // RAM array: cleared on reset, word write on a legal write request.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_hit) begin
      mem_q[req_idx] <= req_wdata;
    end
  end

  // Load path and sticky address-error flag.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      read_valid_q <= 1'b0;
      if (req_active) begin
        if (req_ok) begin
          if (!req_we) begin
            read_data_q  <= mem_q[req_idx];
            read_valid_q <= 1'b1;
          end
        end else begin
          addr_err_q <= 1'b1;
          // A bad load still completes, returning zero.
          if (!req_we) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  // Dump FSM RUN -> DUMP -> DONE with registered handshake outputs.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q      <= StRun;
      busy_q       <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (HALT) begin
            state_q      <= StDump;
            busy_q       <= 1'b1;
            dump_valid_q <= 1'b1;
            dump_addr_q  <= '0;
          end
        end
        StDump: begin
          if (DUMP_READY) begin
            if (dump_addr_q == ADDR_W'(DEPTH - 1)) begin
              state_q      <= StDone;
              busy_q       <= 1'b0;
              dump_valid_q <= 1'b0;
              dump_done_q  <= 1'b1;
            end else begin
              dump_addr_q <= dump_addr_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q <= StDone;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] wr_count_q;
  logic [31:0] rd_count_q;

  // Saturating counters of legal accesses serviced in RUN.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      if (wr_hit && (wr_count_q != '1)) wr_count_q <= wr_count_q + 32'd1;
      if (rd_hit && (rd_count_q != '1)) rd_count_q <= rd_count_q + 32'd1;
    end
  end

  assign WR_COUNT = wr_count_q;
  assign RD_COUNT = rd_count_q;
`else
  assign WR_COUNT = '0;
  assign RD_COUNT = '0;
`endif

  assign READ_DATA  = read_data_q;
  assign READ_VALID = read_valid_q;
  assign ADDR_ERR   = addr_err_q;
  assign BUSY       = busy_q;
  assign DUMP_VALID = dump_valid_q;
  assign DUMP_ADDR  = dump_addr_q;
  assign DUMP_DONE  = dump_done_q;
  // RAM is frozen during the dump, so a direct read is stable under back-pressure.
  assign DUMP_DATA  = mem_q[dump_addr_q];

endmodule

// File: tb/tb_mem_edit_responder.sv
// Self-checking bench for mem_edit_responder against a behavioural RAM model.
module tb_mem_edit_responder;

  localparam int DEPTH = 512;
`ifdef MEM_ACCESS_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        CLOCK;
  logic        RESET_N;
  logic [64:0] EDIT_SERIAL;
  logic        ENABLE_MEM;
  logic        HALT;
  logic [31:0] READ_DATA;
  logic        READ_VALID;
  logic        ADDR_ERR;
  logic        BUSY;
  logic        DUMP_VALID;
  logic        DUMP_READY;
  logic [8:0]  DUMP_ADDR;
  logic [31:0] DUMP_DATA;
  logic        DUMP_DONE;
  logic [31:0] WR_COUNT;
  logic [31:0] RD_COUNT;

  mem_edit_responder dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .EDIT_SERIAL(EDIT_SERIAL),
    .ENABLE_MEM (ENABLE_MEM),
    .HALT       (HALT),
    .READ_DATA  (READ_DATA),
    .READ_VALID (READ_VALID),
    .ADDR_ERR   (ADDR_ERR),
    .BUSY       (BUSY),
    .DUMP_VALID (DUMP_VALID),
    .DUMP_READY (DUMP_READY),
    .DUMP_ADDR  (DUMP_ADDR),
    .DUMP_DATA  (DUMP_DATA),
    .DUMP_DONE  (DUMP_DONE),
    .WR_COUNT   (WR_COUNT),
    .RD_COUNT   (RD_COUNT)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state 0=run, 1=dump, 2=done.
  logic [31:0] m_mem [DEPTH];
  int          m_st;
  logic [31:0] m_rdata;
  bit          m_rvalid;
  bit          m_err;
  int          m_daddr;
  logic [31:0] m_wrc;
  logic [31:0] m_rdc;

  task automatic model_step();
    logic [31:0] a;
    bit          ok;
    bit          we;
    int          idx;
    a   = EDIT_SERIAL[63:32];
    we  = EDIT_SERIAL[64];
    ok  = (a % 4 == 0) && (a < 4 * DEPTH);
    idx = ok ? int'(a / 4) : 0;
    if (!RESET_N) begin
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      m_st = 0; m_rdata = 0; m_rvalid = 0; m_err = 0; m_daddr = 0; m_wrc = 0; m_rdc = 0;
    end else if (m_st == 0) begin
      m_rvalid = 0;
      if (ENABLE_MEM) begin
        if (ok && we) begin
          m_mem[idx] = EDIT_SERIAL[31:0];
          if (m_wrc != 32'hFFFF_FFFF) m_wrc = m_wrc + 1;
        end else if (ok) begin
          m_rdata = m_mem[idx]; m_rvalid = 1;
          if (m_rdc != 32'hFFFF_FFFF) m_rdc = m_rdc + 1;
        end else begin
          m_err = 1;
          if (!we) begin m_rdata = 0; m_rvalid = 1; end
        end
      end
      if (HALT) begin m_st = 1; m_daddr = 0; end
    end else if (m_st == 1) begin
      m_rvalid = 0;
      if (DUMP_READY) begin
        if (m_daddr == DEPTH - 1) m_st = 2;
        else m_daddr = m_daddr + 1;
      end
    end else begin
      m_rvalid = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input bit en, input bit we, input logic [31:0] addr,
                       input logic [31:0] data);
    ENABLE_MEM  = en;
    EDIT_SERIAL = {we, addr, data};
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'h4, $urandom);
    HALT = 1'b0; DUMP_READY = 1'b0; RESET_N = 1'b0;
    tick(); tick();
    n_cmp++; if (READ_DATA !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", READ_DATA); end
    n_cmp++; if (READ_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", READ_VALID); end
    n_cmp++; if (ADDR_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", ADDR_ERR); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (DUMP_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_dvalid: got %b want 0", DUMP_VALID); end
    n_cmp++; if (DUMP_ADDR !== 9'h0) begin n_bad++; $display("FAIL reset_daddr: got %h want 0", DUMP_ADDR); end
    n_cmp++; if (DUMP_DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", DUMP_DONE); end
    n_cmp++; if (WR_COUNT !== 32'h0 || RD_COUNT !== 32'h0) begin
      n_bad++; $display("FAIL reset_counts: got %h/%h want 0/0", WR_COUNT, RD_COUNT);
    end
    RESET_N = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF); tick();
    n_cmp++; if (READ_VALID !== 1'b0) begin n_bad++; $display("FAIL wr_rvalid: got %b want 0", READ_VALID); end
    drive(1'b1, 1'b0, 32'h10, $urandom); tick();
    n_cmp++; if (READ_VALID !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid: got %b want 1", READ_VALID); end
    n_cmp++; if (READ_DATA !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL rd_data: got %h want deadbeef", READ_DATA);
    end
    n_cmp++; if (ADDR_ERR !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", ADDR_ERR); end
  endtask

  task automatic test_enable_off();
    logic [31:0] prev;
    prev = READ_DATA;
    drive(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D); tick();
    n_cmp++; if (READ_VALID !== 1'b0) begin n_bad++; $display("FAIL en0_rvalid: got %b want 0", READ_VALID); end
    n_cmp++; if (READ_DATA !== prev) begin n_bad++; $display("FAIL en0_hold: got %h want %h", READ_DATA, prev); end
    drive(1'b1, 1'b0, 32'h20, 32'h0); tick();
    n_cmp++; if (READ_DATA !== 32'h0 || READ_VALID !== 1'b1) begin
      n_bad++; $display("FAIL en0_word8: got %h/%b want 0/1", READ_DATA, READ_VALID);
    end
  endtask

  task automatic test_addr_err();
    drive(1'b1, 1'b1, 32'h13, 32'h1234); tick();
    n_cmp++; if (ADDR_ERR !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", ADDR_ERR); end
    n_cmp++; if (READ_VALID !== 1'b0) begin n_bad++; $display("FAIL mis_rvalid: got %b want 0", READ_VALID); end
    drive(1'b1, 1'b0, 32'h10, 32'h0); tick();
    n_cmp++; if (READ_DATA !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL mis_word4: got %h want deadbeef", READ_DATA);
    end
    drive(1'b1, 1'b0, 32'h800, 32'h0); tick();
    n_cmp++; if (READ_DATA !== 32'h0 || READ_VALID !== 1'b1) begin
      n_bad++; $display("FAIL oor_read: got %h/%b want 0/1", READ_DATA, READ_VALID);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0); tick();
    n_cmp++; if (ADDR_ERR !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", ADDR_ERR); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 99);
      if (kind < 70) a = 32'($urandom_range(0, 31)) * 4;
      else if (kind < 85) a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
      else a = 32'h800 + $urandom_range(0, 32'h7FFF_0000);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, a, $urandom);
      tick();
      n_cmp++; if (READ_VALID !== m_rvalid) begin
        n_bad++; $display("FAIL rnd_rvalid c=%0d: got %b want %b", c, READ_VALID, m_rvalid);
      end
      n_cmp++; if (READ_DATA !== m_rdata) begin
        n_bad++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, READ_DATA, m_rdata);
      end
      n_cmp++; if (ADDR_ERR !== m_err) begin
        n_bad++; $display("FAIL rnd_err c=%0d: got %b want %b", c, ADDR_ERR, m_err);
      end
      n_cmp++; if (WR_COUNT !== (CntEn ? m_wrc : 32'h0) || RD_COUNT !== (CntEn ? m_rdc : 32'h0)) begin
        n_bad++; $display("FAIL rnd_counts c=%0d: got %h/%h want %h/%h", c, WR_COUNT, RD_COUNT,
                          CntEn ? m_wrc : 32'h0, CntEn ? m_rdc : 32'h0);
      end
    end
  endtask

  task automatic test_counters();
    RESET_N = 1'b0; tick(); RESET_N = 1'b1;
    drive(1'b1, 1'b1, 32'h0, 32'h1); tick();
    drive(1'b1, 1'b1, 32'h4, 32'h2); tick();
    drive(1'b1, 1'b1, 32'h8, 32'h3); tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 1'b0, 32'h4, 32'h0); tick();
    drive(1'b1, 1'b0, 32'h6, 32'h0); tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0); tick();
    n_cmp++; if (WR_COUNT !== (CntEn ? 32'd3 : 32'd0)) begin
      n_bad++; $display("FAIL wr_count: got %0d want %0d", WR_COUNT, CntEn ? 3 : 0);
    end
    n_cmp++; if (RD_COUNT !== (CntEn ? 32'd2 : 32'd0)) begin
      n_bad++; $display("FAIL rd_count: got %0d want %0d", RD_COUNT, CntEn ? 2 : 0);
    end
  endtask

  task automatic test_dump();
    int nexp;
    int cyc;
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 1'b1, 32'($urandom_range(0, DEPTH - 1)) * 4, $urandom); tick();
    end
    drive(1'b1, 1'b1, 32'h0, 32'h55); HALT = 1'b1; DUMP_READY = 1'b0; tick();
    HALT = 1'b0;
    n_cmp++; if (BUSY !== 1'b1 || DUMP_VALID !== 1'b1) begin
      n_bad++; $display("FAIL dump_enter: got busy=%b valid=%b want 1/1", BUSY, DUMP_VALID);
    end
    n_cmp++; if (DUMP_ADDR !== 9'd0 || DUMP_DATA !== 32'h55) begin
      n_bad++; $display("FAIL dump_first: got %0d:%h want 0:55", DUMP_ADDR, DUMP_DATA);
    end
    nexp = 0;
    cyc  = 0;
    while (nexp < DEPTH && cyc < 2 * DEPTH + 20) begin
      DUMP_READY = (cyc % 2 == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            32'($urandom_range(0, DEPTH - 1)) * 4, $urandom);
      HALT = $urandom_range(0, 1) == 1;
      if (DUMP_VALID === 1'b1 && DUMP_READY) begin
        n_cmp++; if (DUMP_ADDR !== 9'(nexp) || DUMP_DATA !== m_mem[nexp]) begin
          n_bad++; $display("FAIL dump_word: got %0d:%h want %0d:%h", DUMP_ADDR, DUMP_DATA,
                            nexp, m_mem[nexp]);
        end
        nexp++;
      end
      tick();
      cyc++;
      n_cmp++; if (READ_VALID !== 1'b0 || BUSY !== (m_st == 1) || DUMP_VALID !== (m_st == 1)) begin
        n_bad++; $display("FAIL dump_ctrl c=%0d: got rv=%b busy=%b dv=%b want 0/%b/%b", cyc,
                          READ_VALID, BUSY, DUMP_VALID, m_st == 1, m_st == 1);
      end
    end
    n_cmp++; if (nexp != DEPTH) begin
      n_bad++; $display("FAIL dump_timeout: got %0d words want %0d", nexp, DEPTH);
    end
    n_cmp++; if (DUMP_DONE !== 1'b1 || BUSY !== 1'b0 || DUMP_VALID !== 1'b0) begin
      n_bad++; $display("FAIL dump_done: got done=%b busy=%b dv=%b want 1/0/0",
                        DUMP_DONE, BUSY, DUMP_VALID);
    end
    HALT = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 1'b1, 32'h0, 32'h99); tick();
    n_cmp++; if (READ_VALID !== 1'b0 || DUMP_DONE !== 1'b1 || BUSY !== 1'b0) begin
      n_bad++; $display("FAIL done_ignore: got rv=%b done=%b busy=%b want 0/1/0",
                        READ_VALID, DUMP_DONE, BUSY);
    end
    HALT = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    int n;
    RESET_N = 1'b0; tick(); RESET_N = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 32'hABCD_0123); tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0); HALT = 1'b1; DUMP_READY = 1'b1; tick();
    HALT = 1'b0;
    n = 0;
    while (DUMP_ADDR !== 9'd100 && n < 300) begin tick(); n++; end
    n_cmp++; if (DUMP_ADDR !== 9'd100) begin
      n_bad++; $display("FAIL mid_reach: got %0d want 100", DUMP_ADDR);
    end
    RESET_N = 1'b0; tick(); RESET_N = 1'b1; DUMP_READY = 1'b0;
    n_cmp++; if (BUSY !== 1'b0 || DUMP_VALID !== 1'b0 || DUMP_ADDR !== 9'd0 || DUMP_DONE !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: got busy=%b dv=%b da=%0d done=%b want 0/0/0/0",
                        BUSY, DUMP_VALID, DUMP_ADDR, DUMP_DONE);
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0); tick();
    n_cmp++; if (READ_VALID !== 1'b1 || READ_DATA !== 32'h0) begin
      n_bad++; $display("FAIL mid_clear: got %h/%b want 0/1", READ_DATA, READ_VALID);
    end
    drive(1'b1, 1'b1, 32'h10, 32'h7); tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0); tick();
    n_cmp++; if (READ_DATA !== 32'h7) begin
      n_bad++; $display("FAIL mid_run: got %h want 7", READ_DATA);
    end
  endtask

  initial begin
    RESET_N = 1'b0; HALT = 1'b0; DUMP_READY = 1'b0;
    ENABLE_MEM = 1'b0; EDIT_SERIAL = '0;
    #2;
    test_reset();
    test_write_read();
    test_enable_off();
    test_addr_err();
    test_random();
    test_counters();
    test_dump();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
